// File: rtl/hilo_ctrl_pkg.sv
// Shared HI/LO controller definitions: hilo_op bit positions, FSM states, operation kinds.
// Pure declarations; no timing or flow-control behaviour of its own.
package hilo_ctrl_pkg;

  localparam int XLEN = 32;

  // hilo_op is {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}, MSB first
  localparam int OP_MFHI  = 8;
  localparam int OP_MFLO  = 7;
  localparam int OP_MTHI  = 6;
  localparam int OP_MTLO  = 5;
  localparam int OP_MULT  = 4;
  localparam int OP_MULTU = 3;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 1;
  localparam int OP_MUL   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_MULT = 2'd0,
    K_MUL  = 2'd1,
    K_DIV  = 2'd2
  } kind_t;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; start does the first step, then one step per cycle.
// done rises DIV_CYCLES-1 cycles after start; no backpressure, a new start restarts it.
module hilo_ctrl_div_iter
  import hilo_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_in, quo_in, dsr_in, rem_nx, quo_nx;
  logic [XLEN:0]   trial, diff;

  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dsr_in = start ? divisor : dsr_q;
    trial  = {rem_in, quo_in[XLEN-1]};
    diff   = trial - {1'b0, dsr_in};
    // borrow out means the trial subtraction did not fit: restore
    if (!diff[XLEN]) begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo_in[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      dsr_q <= divisor;
      cnt_q <= 6'(DIV_CYCLES - 1);
    end else if (cnt_q != 6'd0) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (cnt_q == 6'd0);

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO owner sequencing multi-cycle mult/div; commits once on entry to DONE.
// stallreq covers issue + MUL_CYCLES (mul) or DIV_CYCLES (div) cycles; DONE waits out stall_ex.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic [8:0]  hilo_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic [31:0] hilo_rdata,
  output logic [31:0] mul_res,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  state_t             state_q;
  kind_t              kind_q;
  logic [31:0]        hi_q, lo_q, mul_res_q, dvd_q;
  logic [5:0]         cnt_q;
  logic signed [63:0] op_a_q, op_b_q, prod_w;
  logic               neg_q_q, neg_r_q, dz_q;

  logic        is_md, is_div, sgn_mul, issue, div_start, div_done;
  logic [31:0] quotient, remainder, q_fix, r_fix;

  assign is_div  = hilo_op[OP_DIV] | hilo_op[OP_DIVU];
  assign is_md   = hilo_op[OP_MULT] | hilo_op[OP_MULTU] | hilo_op[OP_MUL] | is_div;
  assign sgn_mul = hilo_op[OP_MULT] | hilo_op[OP_MUL];
  assign issue   = (state_q == ST_IDLE) & valid_i & ~flush & is_md;
  assign div_start = issue & is_div;

  hilo_ctrl_div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mag(src1, hilo_op[OP_DIV])),
    .divisor  (mag(src2, hilo_op[OP_DIV])),
    .quotient (quotient),
    .remainder(remainder),
    .done     (div_done)
  );

  // operands are pre-extended to 64 bits, so the low 64 product bits are exact
  assign prod_w = op_a_q * op_b_q;
  assign q_fix  = neg_q_q ? -quotient : quotient;
  assign r_fix  = neg_r_q ? -remainder : remainder;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      kind_q    <= K_MULT;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_res_q <= '0;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      dvd_q     <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= is_div ? ST_DIV : ST_MUL;
            kind_q  <= is_div ? K_DIV : (hilo_op[OP_MUL] ? K_MUL : K_MULT);
            cnt_q   <= 6'(MUL_CYCLES - 1);
            op_a_q  <= sgn_mul ? {{32{src1[31]}}, src1} : {32'd0, src1};
            op_b_q  <= sgn_mul ? {{32{src2[31]}}, src2} : {32'd0, src2};
            neg_q_q <= hilo_op[OP_DIV] & (src1[31] ^ src2[31]);
            neg_r_q <= hilo_op[OP_DIV] & src1[31];
            dz_q    <= (src2 == 32'd0);
            dvd_q   <= src1;
          end else if (valid_i && !stall_ex) begin
            if (hilo_op[OP_MTHI]) hi_q <= src1;
            if (hilo_op[OP_MTLO]) lo_q <= src1;
          end
        end
        ST_MUL: begin
          if (cnt_q == 6'd0) begin
            state_q <= ST_DONE;
            if (kind_q == K_MUL) begin
              mul_res_q <= prod_w[31:0];
            end else begin
              hi_q <= prod_w[63:32];
              lo_q <= prod_w[31:0];
            end
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_q <= ST_DONE;
            if (dz_q) begin
              lo_q <= '1;
              hi_q <= dvd_q;
            end else begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
          end
        end
        ST_DONE: begin
          if (!stall_ex) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stallreq   = rst & ~flush & (issue | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign hilo_rdata = !rst ? 32'd0 :
                      hilo_op[OP_MFHI] ? hi_q :
                      hilo_op[OP_MFLO] ? lo_q : 32'd0;
  assign mul_res    = rst ? mul_res_q : 32'd0;
  assign hi_o       = rst ? hi_q : 32'd0;
  assign lo_o       = rst ? lo_q : 32'd0;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed scoreboard bench for hilo_ctrl: expected commits queued at issue, compared in DONE.
module tb_hilo_ctrl;

  localparam logic [8:0] B_MFHI  = 9'h100;
  localparam logic [8:0] B_MFLO  = 9'h080;
  localparam logic [8:0] B_MTHI  = 9'h040;
  localparam logic [8:0] B_MTLO  = 9'h020;
  localparam logic [8:0] B_MULT  = 9'h010;
  localparam logic [8:0] B_MULTU = 9'h008;
  localparam logic [8:0] B_DIV   = 9'h004;
  localparam logic [8:0] B_DIVU  = 9'h002;
  localparam logic [8:0] B_MUL   = 9'h001;

  logic        clk, rst, valid_i, flush, stall_ex;
  logic [8:0]  hilo_op;
  logic [31:0] src1, src2;
  logic        stallreq;
  logic [31:0] hilo_rdata, mul_res, hi_o, lo_o;

  hilo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .flush     (flush),
    .stall_ex  (stall_ex),
    .hilo_op   (hilo_op),
    .src1      (src1),
    .src2      (src2),
    .stallreq  (stallreq),
    .hilo_rdata(hilo_rdata),
    .mul_res   (mul_res),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mres;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl_hi, mdl_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div op, count stallreq cycles, check the commit in DONE,
  // optionally hold DONE with stall_ex for 'hold' cycles.
  task automatic run_op(input string tag, input logic [8:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] emres, input int estalls, input int hold);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo; e.mres = emres; e.stalls = estalls;
    sb.push_back(e);
    valid_i = 1'b1; hilo_op = op; src1 = a; src2 = b;
    #1;
    n = 0;
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    e = sb.pop_front();
    chk({tag, " stall_cycles"}, 32'(n), 32'(e.stalls));
    chk({tag, " hi"}, hi_o, e.hi);
    chk({tag, " lo"}, lo_o, e.lo);
    if (op == B_MUL) chk({tag, " mul_res"}, mul_res, e.mres);
    mdl_hi = e.hi;
    mdl_lo = e.lo;
    if (hold > 0) begin
      stall_ex = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #2;
        chk({tag, " hold stallreq"}, {31'd0, stallreq}, 32'd0);
        chk({tag, " hold hi"}, hi_o, e.hi);
        chk({tag, " hold lo"}, lo_o, e.lo);
        if (op == B_MUL) chk({tag, " hold mul_res"}, mul_res, e.mres);
      end
      stall_ex = 1'b0;
    end
    valid_i = 1'b0; hilo_op = '0;
    tick();
  endtask

  // Issue an op and flush it during stall cycle 'cyc' (1 = issue cycle).
  task automatic flush_at(input string tag, input logic [8:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int cyc);
    valid_i = 1'b1; hilo_op = op; src1 = a; src2 = b;
    #1;
    for (int n = 1; n < cyc; n++) begin
      @(posedge clk);
      #2;
    end
    chk({tag, " pre-flush stallreq"}, {31'd0, stallreq}, 32'd1);
    flush = 1'b1;
    #1;
    chk({tag, " flush stallreq"}, {31'd0, stallreq}, 32'd0);
    tick();
    flush = 1'b0; valid_i = 1'b0; hilo_op = '0;
    #1;
    chk({tag, " after stallreq"}, {31'd0, stallreq}, 32'd0);
    chk({tag, " after hi"}, hi_o, mdl_hi);
    chk({tag, " after lo"}, lo_o, mdl_lo);
    repeat (3) tick();
    chk({tag, " later hi"}, hi_o, mdl_hi);
    chk({tag, " later lo"}, lo_o, mdl_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid_i = 1'b1; flush = 1'b0; stall_ex = 1'b0;
    hilo_op = B_MULT; src1 = 32'd5; src2 = 32'd6;
    mdl_hi = '0; mdl_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stallreq", {31'd0, stallreq}, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    chk("reset mul_res", mul_res, 32'd0);
    hilo_op = B_MFHI;
    #1;
    chk("reset hilo_rdata", hilo_rdata, 32'd0);
    valid_i = 1'b0; hilo_op = '0; rst = 1'b1;
    tick();

    // op without valid_i is ignored
    hilo_op = B_DIV; src1 = 32'd9; src2 = 32'd2;
    #1;
    chk("novalid stallreq", {31'd0, stallreq}, 32'd0);
    tick();
    chk("novalid stallreq next", {31'd0, stallreq}, 32'd0);
    hilo_op = '0;

    run_op("mult", B_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 3, 0);
    run_op("multu", B_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'd0, 3, 0);
    run_op("mul", B_MUL, 32'd7, 32'hFFFF_FFFB, mdl_hi, mdl_lo, 32'hFFFF_FFDD, 3, 2);
    run_op("div_neg", B_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 33, 0);
    run_op("div_negdsr", B_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32'd0, 33, 0);
    run_op("divu_by0", B_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("div_by0", B_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("div_ovf", B_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 33, 0);
    run_op("divu_big", B_DIVU, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 32'd0, 33, 0);

    flush_at("flush_div10", B_DIV, 32'd1000, 32'd7, 10);

    valid_i = 1'b1; hilo_op = B_MTHI; src1 = 32'h1234;
    tick();
    mdl_hi = 32'h1234;
    hilo_op = B_MFHI;
    #1;
    chk("mfhi after mthi", hilo_rdata, 32'h1234);
    hilo_op = B_MFLO;
    #1;
    chk("mflo", hilo_rdata, mdl_lo);

    // mtlo blocked while EX is stalled
    hilo_op = B_MTLO; src1 = 32'hDEAD; stall_ex = 1'b1;
    tick();
    stall_ex = 1'b0;
    chk("mtlo stalled lo", lo_o, mdl_lo);
    src1 = 32'hBEEF;
    tick();
    mdl_lo = 32'hBEEF;
    chk("mtlo lo", lo_o, 32'hBEEF);
    valid_i = 1'b0; hilo_op = '0;
    tick();

    flush_at("flush_div_last", B_DIV, 32'd50, 32'd3, 33);
    flush_at("flush_mult_last", B_MULT, 32'd11, 32'd13, 3);

    run_op("divu_hold", B_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 32'd0, 33, 3);
    valid_i = 1'b1; hilo_op = B_MTHI; src1 = 32'h77;
    tick();
    valid_i = 1'b0; hilo_op = '0;
    chk("idle after hold hi", hi_o, 32'h77);

    // reset in the middle of a multiply aborts it and clears HI/LO
    valid_i = 1'b1; hilo_op = B_MULTU; src1 = 32'd3; src2 = 32'd4;
    tick();
    rst = 1'b0; valid_i = 1'b0; hilo_op = '0;
    #1;
    chk("midrst stallreq", {31'd0, stallreq}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst stallreq after", {31'd0, stallreq}, 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst lo", lo_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
